led_state_monitor: RTL and testbench

- Receive-side counterpart of the bound-flasher LED decoder: it reads the 16-bit thermometer LED bus and encodes it back into a lit-LED count.
- Tracks the sweep direction with an FSM, reports bound reversals ("bounces"), and flags illegal patterns and over-size steps.
- Instantiated beside the flasher top, sharing its clock, as an on-chip self-check and status source.

---
 rtl/led_mon_pkg.sv | 17 +
 rtl/led_state_monitor_thermo_encoder.sv | 32 +++
 rtl/led_state_monitor.sv | 145 ++++++++++++++
 tb/tb_led_state_monitor.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/led_mon_pkg.sv
// led_mon_pkg
// Shared definitions for the LED state monitor: the sweep-direction
// encoding reported on the dir output and default bus/count widths.
package led_mon_pkg;

    // Direction encoding seen on the dir output.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        FLAT = 2'b01,
        UP   = 2'b10,
        DOWN = 2'b11
    } dir_e;

    localparam int LED_W_DEF = 16;
    localparam int CNT_W_DEF = $clog2(LED_W_DEF + 1);

endpackage : led_mon_pkg

// File: rtl/led_state_monitor_thermo_encoder.sv
// thermo_encoder
// Purely combinational thermometer-to-count encoder.
// Ports:
//   led   : LED_W-bit thermometer input (bits [k-1:0] lit, rest dark)
//   count : number of lit LEDs (only meaningful when legal=1)
//   legal : 1 when led is a thermometer code (all-zero included)
module thermo_encoder #(
    parameter int LED_W = 16,
    parameter int CNT_W = 5
) (
    input  logic [LED_W-1:0] led,
    output logic [CNT_W-1:0] count,
    output logic             legal
);

    logic [LED_W:0] led_ext;
    logic [LED_W:0] led_plus1;

    // A thermometer code is 2^k - 1, so adding one carries through every
    // lit bit and leaves no overlap with the original value.
    assign led_ext   = {1'b0, led};
    assign led_plus1 = led_ext + (LED_W+1)'(1);
    assign legal     = ((led_ext & led_plus1) == '0);

    always_comb begin
        count = '0;
        for (int i = 0; i < LED_W; i++) begin
            count = count + CNT_W'(led[i]);
        end
    end

endmodule : thermo_encoder

// File: rtl/led_state_monitor.sv
// led_state_monitor
// Watches a thermometer-coded LED bus, encodes it back to a lit-LED count,
// tracks sweep direction with a small FSM, counts bound reversals and flags
// illegal patterns and over-size steps.
//
// Handshake: sample_en is a plain strobe with no back-pressure; led_state is
// taken on a rising clk edge only when sample_en=1, and every output reflects
// that sample one cycle later (registered). Pulse outputs are high for one
// cycle per causing sample.
//
// Ports:
//   clk, rst_n    : clock, synchronous active-low reset
//   sample_en     : sample strobe
//   led_state     : LED bus under observation
//   count         : lit-LED count of the last legal sample
//   count_valid   : at least one legal sample taken since reset
//   dir           : FSM state (IDLE/FLAT/UP/DOWN), doubles as state debug
//   bounce_pulse  : one-cycle pulse on an UP<->DOWN reversal
//   bounce_cnt    : saturating reversal count
//   err_pattern   : one-cycle pulse on a non-thermometer sample
//   err_step      : one-cycle pulse on |delta| > MAX_STEP
//
// Build option: LED_MON_STEP_CHECK_EN enables the step-size check; without
// it err_step is constant 0 and MAX_STEP has no effect.
module led_state_monitor
    import led_mon_pkg::*;
#(
    parameter int LED_W    = LED_W_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int MAX_STEP = 1,
    parameter int BOUNCE_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sample_en,
    input  logic [LED_W-1:0]    led_state,
    output logic [CNT_W-1:0]    count,
    output logic                count_valid,
    output logic [1:0]          dir,
    output logic                bounce_pulse,
    output logic [BOUNCE_W-1:0] bounce_cnt,
    output logic                err_pattern,
    output logic                err_step
);

    logic [CNT_W-1:0] enc_count;
    logic             enc_legal;

    thermo_encoder #(
        .LED_W (LED_W),
        .CNT_W (CNT_W)
    ) u_enc (
        .led   (led_state),
        .count (enc_count),
        .legal (enc_legal)
    );

    dir_e                state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                count_valid_q, count_valid_d;
    logic                bounce_pulse_q, bounce_pulse_d;
    logic [BOUNCE_W-1:0] bounce_cnt_q, bounce_cnt_d;
    logic                err_pattern_q, err_pattern_d;
    logic                err_step_q, err_step_d;

    // One extra bit so 0..LED_W differences never overflow.
    logic signed [CNT_W:0] delta;
    logic                  step_big;

    assign delta = $signed({1'b0, enc_count}) - $signed({1'b0, count_q});

`ifdef LED_MON_STEP_CHECK_EN
    logic [CNT_W:0] delta_mag;
    assign delta_mag = delta[CNT_W] ? CNT_W'(0) - delta : delta;
    assign step_big  = (delta_mag > (CNT_W+1)'(MAX_STEP));
`else
    // Constant 0; the comparison against MAX_STEP folds away at elaboration.
    assign step_big = 1'b0 & (MAX_STEP < 0);
`endif

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        count_valid_d  = count_valid_q;
        bounce_cnt_d   = bounce_cnt_q;
        bounce_pulse_d = 1'b0;
        err_pattern_d  = 1'b0;
        err_step_d     = 1'b0;

        if (sample_en) begin
            if (!enc_legal) begin
                // Illegal samples leave all tracking state untouched.
                err_pattern_d = 1'b1;
            end else if (state_q == IDLE) begin
                count_d       = enc_count;
                count_valid_d = 1'b1;
                state_d       = FLAT;
            end else begin
                count_d    = enc_count;
                err_step_d = step_big;
                if (delta > 0) begin
                    state_d = UP;
                end else if (delta < 0) begin
                    state_d = DOWN;
                end
                if ((state_q == UP && state_d == DOWN) ||
                    (state_q == DOWN && state_d == UP)) begin
                    bounce_pulse_d = 1'b1;
                    if (bounce_cnt_q != '1) begin
                        bounce_cnt_d = bounce_cnt_q + BOUNCE_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            count_q        <= '0;
            count_valid_q  <= 1'b0;
            bounce_pulse_q <= 1'b0;
            bounce_cnt_q   <= '0;
            err_pattern_q  <= 1'b0;
            err_step_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            count_valid_q  <= count_valid_d;
            bounce_pulse_q <= bounce_pulse_d;
            bounce_cnt_q   <= bounce_cnt_d;
            err_pattern_q  <= err_pattern_d;
            err_step_q     <= err_step_d;
        end
    end

    assign count        = count_q;
    assign count_valid  = count_valid_q;
    assign dir          = state_q;
    assign bounce_pulse = bounce_pulse_q;
    assign bounce_cnt   = bounce_cnt_q;
    assign err_pattern  = err_pattern_q;
    assign err_step     = err_step_q;

endmodule : led_state_monitor

// File: tb/tb_led_state_monitor.sv
// tb_led_state_monitor
// Table-driven bench for led_state_monitor: a vector table of
// {rst_n, sample_en, led_state, expected outputs}, plus a long alternating
// sequence for bounce-counter saturation and a mid-run reset.
module tb_led_state_monitor;

    localparam int LED_W    = 16;
    localparam int CNT_W    = 5;
    localparam int BOUNCE_W = 8;
    localparam int EXP_W    = CNT_W + 1 + 2 + 1 + BOUNCE_W + 1 + 1;

`ifdef LED_MON_STEP_CHECK_EN
    localparam logic STEP_ON = 1'b1;
`else
    localparam logic STEP_ON = 1'b0;
`endif

    localparam logic [1:0] D_IDLE = 2'b00;
    localparam logic [1:0] D_FLAT = 2'b01;
    localparam logic [1:0] D_UP   = 2'b10;
    localparam logic [1:0] D_DOWN = 2'b11;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic                sample_en;
    logic [LED_W-1:0]    led_state;
    logic [CNT_W-1:0]    count;
    logic                count_valid;
    logic [1:0]          dir;
    logic                bounce_pulse;
    logic [BOUNCE_W-1:0] bounce_cnt;
    logic                err_pattern;
    logic                err_step;

    led_state_monitor #(
        .LED_W    (LED_W),
        .CNT_W    (CNT_W),
        .MAX_STEP (1),
        .BOUNCE_W (BOUNCE_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_en    (sample_en),
        .led_state    (led_state),
        .count        (count),
        .count_valid  (count_valid),
        .dir          (dir),
        .bounce_pulse (bounce_pulse),
        .bounce_cnt   (bounce_cnt),
        .err_pattern  (err_pattern),
        .err_step     (err_step)
    );

    // ---------------- scoreboard ----------------
    logic [EXP_W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [EXP_W-1:0] pack_exp(
        input logic [CNT_W-1:0] c, input logic cv, input logic [1:0] d,
        input logic bp, input logic [BOUNCE_W-1:0] bc, input logic ep,
        input logic es);
        return {c, cv, d, bp, bc, ep, es};
    endfunction

    // Drive one cycle, push the expectation, sample #1 after the edge.
    task automatic apply(input string name, input logic r, input logic en,
                         input logic [LED_W-1:0] led,
                         input logic [EXP_W-1:0] exp_v);
        logic [EXP_W-1:0] act;
        logic [EXP_W-1:0] want;
        rst_n     = r;
        sample_en = en;
        led_state = led;
        exp_q.push_back(exp_v);
        @(posedge clk);
        #1;
        act  = {count, count_valid, dir, bounce_pulse, bounce_cnt,
                err_pattern, err_step};
        want = exp_q.pop_front();
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got cnt=%0d cv=%0b dir=%0d bp=%0b bcnt=%0d ep=%0b es=%0b, want cnt=%0d cv=%0b dir=%0d bp=%0b bcnt=%0d ep=%0b es=%0b",
                     name, count, count_valid, dir, bounce_pulse, bounce_cnt,
                     err_pattern, err_step,
                     want[EXP_W-1 -: CNT_W], want[EXP_W-1-CNT_W],
                     want[EXP_W-2-CNT_W -: 2], want[EXP_W-4-CNT_W],
                     want[BOUNCE_W+1 : 2], want[1], want[0]);
        end
        // Inputs return to idle between strobes.
        sample_en = 1'b0;
    endtask

    typedef struct {
        string               name;
        logic                rst_n;
        logic                en;
        logic [LED_W-1:0]    led;
        logic [CNT_W-1:0]    cnt;
        logic                cv;
        logic [1:0]          dir;
        logic                bp;
        logic [BOUNCE_W-1:0] bcnt;
        logic                ep;
        logic                es;   // expected only when step check is built
    } vec_t;

    vec_t vecs[22];

    // Watchdog: the run is purely clock-counted, this only guards against a stall.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        sample_en = 1'b0;
        led_state = '0;

        vecs[0]  = '{"reset_with_sample",  0, 1, 16'h00FF,  0, 0, D_IDLE, 0, 0, 0, 0};
        vecs[1]  = '{"reset_hold",         0, 1, 16'h00FF,  0, 0, D_IDLE, 0, 0, 0, 0};
        vecs[2]  = '{"first_zero",         1, 1, 16'h0000,  0, 1, D_FLAT, 0, 0, 0, 0};
        vecs[3]  = '{"sweep_1",            1, 1, 16'h0001,  1, 1, D_UP,   0, 0, 0, 0};
        vecs[4]  = '{"sweep_2",            1, 1, 16'h0003,  2, 1, D_UP,   0, 0, 0, 0};
        vecs[5]  = '{"sweep_3",            1, 1, 16'h0007,  3, 1, D_UP,   0, 0, 0, 0};
        vecs[6]  = '{"no_strobe_hold",     1, 0, 16'h0005,  3, 1, D_UP,   0, 0, 0, 0};
        vecs[7]  = '{"illegal_0005",       1, 1, 16'h0005,  3, 1, D_UP,   0, 0, 1, 0};
        vecs[8]  = '{"after_illegal_000F", 1, 1, 16'h000F,  4, 1, D_UP,   0, 0, 0, 0};
        vecs[9]  = '{"jump_to_full",       1, 1, 16'hFFFF, 16, 1, D_UP,   0, 0, 0, 1};
        vecs[10] = '{"bounce_down",        1, 1, 16'h7FFF, 15, 1, D_DOWN, 1, 1, 0, 0};
        vecs[11] = '{"pulse_clears",       1, 0, 16'hFFFF, 15, 1, D_DOWN, 0, 1, 0, 0};
        vecs[12] = '{"bounce_up",          1, 1, 16'hFFFF, 16, 1, D_UP,   1, 2, 0, 0};
        vecs[13] = '{"flat_keeps_up",      1, 1, 16'hFFFF, 16, 1, D_UP,   0, 2, 0, 0};
        vecs[14] = '{"illegal_8000",       1, 1, 16'h8000, 16, 1, D_UP,   0, 2, 1, 0};
        vecs[15] = '{"big_drop",           1, 1, 16'h0003,  2, 1, D_DOWN, 1, 3, 0, 1};
        vecs[16] = '{"step_2_to_6",        1, 1, 16'h003F,  6, 1, D_UP,   1, 4, 0, 1};
        vecs[17] = '{"reset_mid_sweep",    0, 1, 16'h0001,  0, 0, D_IDLE, 0, 0, 0, 0};
        vecs[18] = '{"first_after_reset",  1, 1, 16'h0003,  2, 1, D_FLAT, 0, 0, 0, 0};
        vecs[19] = '{"flat_stays_flat",    1, 1, 16'h0003,  2, 1, D_FLAT, 0, 0, 0, 0};
        vecs[20] = '{"flat_to_down",       1, 1, 16'h0001,  1, 1, D_DOWN, 0, 0, 0, 0};
        vecs[21] = '{"down_keeps_down",    1, 1, 16'h0000,  0, 1, D_DOWN, 0, 0, 0, 0};

        @(negedge clk);
        foreach (vecs[i]) begin
            apply(vecs[i].name, vecs[i].rst_n, vecs[i].en, vecs[i].led,
                  pack_exp(vecs[i].cnt, vecs[i].cv, vecs[i].dir, vecs[i].bp,
                           vecs[i].bcnt, vecs[i].ep, vecs[i].es & STEP_ON));
        end

        // Saturation: reset, then 300 alternating 1/3-LED samples. The first
        // sample is FLAT, the second FLAT->UP (no bounce), every later one is
        // a reversal; the counter must stop at 255 while pulses continue.
        apply("sat_reset", 1'b0, 1'b0, 16'h0000,
              pack_exp(0, 0, D_IDLE, 0, 0, 0, 0));
        for (int i = 0; i < 300; i++) begin
            logic [LED_W-1:0]    led_v;
            logic [CNT_W-1:0]    c_v;
            logic [1:0]          d_v;
            logic [BOUNCE_W-1:0] bc_v;
            int                  nb;
            led_v = (i % 2 == 0) ? 16'h0001 : 16'h0003;
            c_v   = (i % 2 == 0) ? 5'd1 : 5'd2;
            d_v   = (i == 0) ? D_FLAT : ((i % 2 == 1) ? D_UP : D_DOWN);
            nb    = (i >= 2) ? i - 1 : 0;
            bc_v  = (nb > 255) ? 8'd255 : 8'(nb);
            apply($sformatf("sat_%0d", i), 1'b1, 1'b1, led_v,
                  pack_exp(c_v, 1'b1, d_v, (i >= 2), bc_v, 1'b0, 1'b0));
        end

        // Reset right after saturation, then the next legal sample is "first".
        apply("sat_mid_reset", 1'b0, 1'b1, 16'h0003,
              pack_exp(0, 0, D_IDLE, 0, 0, 0, 0));
        apply("sat_first_after", 1'b1, 1'b1, 16'h0007,
              pack_exp(3, 1, D_FLAT, 0, 0, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_led_state_monitor
